ping_scheduler: RTL and testbench
=================================

PING_SCHEDULER -- requirements
Module: ping_scheduler

Interface
REQ-001 SHALL have parameters: CLK_MHZ, default 50, clock frequency in MHz; NUM_SENSORS, default 2, sensor count (1..4); TRIGGER_PULSE_US, default 12, trigger width; TIMEOUT_MS, default 25, echo timeout; GUARD_US, default 10000, quiet gap between pings.
REQ-002 SHALL have ports, in this order:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous, active-high reset
  enable_mask  input  NUM_SENSORS  per-sensor ping enable
  echo  input  NUM_SENSORS  sensor echo lines
  trig  output  NUM_SENSORS  sensor trigger lines, at most one high at a time
  dist_raw  output  21  echo width in clk cycles
  dist_id  output  2  index of the sensor that produced dist_raw
  dist_valid  output  1  one-cycle result strobe
  dist_timeout  output  1  qualifies dist_valid; result is a timeout
  busy  output  1  high in any state other than IDLE

Function
REQ-003 SHALL derive COUNT_TRIG = CLK_MHZ*TRIGGER_PULSE_US, COUNT_TIMEOUT = CLK_MHZ*TIMEOUT_MS*1000 and COUNT_GUARD = CLK_MHZ*GUARD_US.
REQ-004 SHALL implement the states IDLE, TRIG, WAIT_ECHO, MEASURE and GUARD, with one 21-bit saturating counter cleared on every state entry.
REQ-005 IDLE: SHALL select the next enabled sensor round-robin, starting after the last-served index (index 0 first after reset), and go to TRIG; SHALL stay in IDLE while enable_mask is all zero.
REQ-006 TRIG: trig[sel] SHALL be high for exactly COUNT_TRIG cycles, then the block goes to WAIT_ECHO.
REQ-007 WAIT_ECHO: SHALL wait for a rising edge of echo[sel] (sampled low then high), so a level already high on entry is ignored; on the edge it goes to MEASURE.
REQ-008 WAIT_ECHO: if COUNT_TIMEOUT cycles elapse with no edge, SHALL emit a timeout result and go to GUARD.
REQ-009 MEASURE: the counter SHALL increment on each cycle echo[sel] is sampled high; on the first sample low, SHALL emit dist_raw equal to the count and go to GUARD.
REQ-010 MEASURE: if the count reaches COUNT_TIMEOUT, SHALL emit a timeout result and go to GUARD.
REQ-011 Result emission SHALL occur in the cycle after the deciding sample: dist_valid high for exactly one cycle, with dist_id = sel and dist_raw/dist_id held until the next emission.
REQ-012 A timeout result SHALL have dist_raw = COUNT_TIMEOUT and dist_timeout = 1; a normal result SHALL have dist_timeout = 0.
REQ-013 GUARD: all trig lines SHALL be low for COUNT_GUARD cycles, then the block returns to IDLE; echo activity during GUARD SHALL be ignored.
REQ-014 sel SHALL be latched in IDLE; clearing enable_mask[sel] mid-slot SHALL NOT abort the slot, and takes effect at the next IDLE.
REQ-015 Echo activity on non-selected sensors SHALL be ignored in every state.
REQ-016 Each parameter-derived count SHALL fit 21 bits; elaboration SHALL fail otherwise.

Reset
REQ-017 rst high SHALL immediately force: state IDLE, trig all zero, dist_valid 0, dist_timeout 0, dist_raw 0, dist_id 0, busy 0, counter 0, round-robin pointer to index 0.
REQ-018 Reset asserted mid-slot SHALL discard the slot with no result emitted; after release, the first ping goes to the lowest enabled index.

Configuration
REQ-019 With PING_SCHED_ECHO_SYNC_EN defined, each echo bit SHALL pass through a two-flop synchronizer before use, adding exactly 2 cycles to every echo-edge reaction.
REQ-020 Without PING_SCHED_ECHO_SYNC_EN, echo SHALL be sampled directly, and the edge timing in REQ-007 and REQ-009 applies with no added latency.

Structure
REQ-021 A shared package ping_sched_pkg SHALL hold the state enumeration, the 21-bit distance width constant and the default parameter values.
REQ-022 The synchronizer SHALL be a sub-module echo_sync, parameterized by width and instantiated only under PING_SCHED_ECHO_SYNC_EN.

Verification (CLK_MHZ=1, TRIGGER_PULSE_US=3, TIMEOUT_MS=1 so COUNT_TIMEOUT=1000, GUARD_US=20, NUM_SENSORS=2, sync macro off)
REQ-023 mask=2'b11, echo0 high for 150 cycles starting 10 cycles after trig0 falls -> trig0 high 3 cycles; dist_valid with dist_id=0, dist_raw=150, dist_timeout=0; after a 20-cycle guard, trig1 rises.
REQ-024 mask=2'b01, echo0 never rises -> dist_valid exactly 1000 cycles after WAIT_ECHO entry, dist_raw=1000, dist_timeout=1; next ping again on sensor 0.
REQ-025 echo0 held high through trig0 and into WAIT_ECHO, then low, then a high pulse of 40 cycles -> dist_raw=40.
REQ-026 mask=2'b00 -> busy=0, trig=0 indefinitely; set mask=2'b10 -> trig1 rises within 2 cycles.
REQ-027 rst pulsed during MEASURE of sensor 1 -> trig=0 and busy=0 asynchronously, no dist_valid; after release, the first trig is on sensor 0.
REQ-028 Macro defined, repeat REQ-023 -> dist_raw=150, with dist_valid 2 cycles later than in REQ-023.

Source files
------------

// File: rtl/ping_sched_pkg.sv
// Shared definitions for the ultrasonic ping scheduler: FSM states, distance
// width, default timing parameters and a saturating increment helper.
package ping_sched_pkg;

  localparam int unsigned DIST_W = 21;

  localparam int unsigned DEF_CLK_MHZ          = 50;
  localparam int unsigned DEF_NUM_SENSORS      = 2;
  localparam int unsigned DEF_TRIGGER_PULSE_US = 12;
  localparam int unsigned DEF_TIMEOUT_MS       = 25;
  localparam int unsigned DEF_GUARD_US         = 10000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GUARD     = 3'd4
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (&v) ? v : v + DIST_W'(1);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for asynchronous echo lines; used only when
// PING_SCHED_ECHO_SYNC_EN is defined.
module echo_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ping_scheduler.sv
// Round-robin ultrasonic ping scheduler: trigger, echo-width measurement with
// timeout, guard gap. Define PING_SCHED_ECHO_SYNC_EN to synchronize echo inputs.
module ping_scheduler
  import ping_sched_pkg::*;
#(
  parameter int unsigned CLK_MHZ          = DEF_CLK_MHZ,
  parameter int unsigned NUM_SENSORS      = DEF_NUM_SENSORS,
  parameter int unsigned TRIGGER_PULSE_US = DEF_TRIGGER_PULSE_US,
  parameter int unsigned TIMEOUT_MS       = DEF_TIMEOUT_MS,
  parameter int unsigned GUARD_US         = DEF_GUARD_US
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] enable_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [DIST_W-1:0]      dist_raw,
  output logic [1:0]             dist_id,
  output logic                   dist_valid,
  output logic                   dist_timeout,
  output logic                   busy
);

  localparam longint unsigned COUNT_TRIG_L    = 64'(CLK_MHZ) * 64'(TRIGGER_PULSE_US);
  localparam longint unsigned COUNT_TIMEOUT_L = 64'(CLK_MHZ) * 64'(TIMEOUT_MS) * 64'd1000;
  localparam longint unsigned COUNT_GUARD_L   = 64'(CLK_MHZ) * 64'(GUARD_US);
  localparam longint unsigned DIST_MAX_L      = (64'd1 << DIST_W) - 64'd1;

  if (NUM_SENSORS < 1 || NUM_SENSORS > 4) begin : g_bad_num_sensors
    $error("ping_scheduler: NUM_SENSORS must be 1..4");
  end
  if (COUNT_TRIG_L < 1 || COUNT_TRIG_L > DIST_MAX_L) begin : g_bad_trig
    $error("ping_scheduler: COUNT_TRIG must be 1..2^21-1");
  end
  if (COUNT_TIMEOUT_L < 1 || COUNT_TIMEOUT_L > DIST_MAX_L) begin : g_bad_timeout
    $error("ping_scheduler: COUNT_TIMEOUT must be 1..2^21-1");
  end
  if (COUNT_GUARD_L < 1 || COUNT_GUARD_L > DIST_MAX_L) begin : g_bad_guard
    $error("ping_scheduler: COUNT_GUARD must be 1..2^21-1");
  end

  localparam logic [DIST_W-1:0] CNT_TIMEOUT  = DIST_W'(COUNT_TIMEOUT_L);
  localparam logic [DIST_W-1:0] TRIG_LAST    = DIST_W'(COUNT_TRIG_L - 64'd1);
  localparam logic [DIST_W-1:0] TIMEOUT_LAST = DIST_W'(COUNT_TIMEOUT_L - 64'd1);
  localparam logic [DIST_W-1:0] GUARD_LAST   = DIST_W'(COUNT_GUARD_L - 64'd1);

  state_e                   state_q, state_d;
  logic [DIST_W-1:0]        cnt_q, cnt_d;
  logic [1:0]               sel_q, sel_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [NUM_SENSORS-1:0]   trig_q, trig_d;
  logic [DIST_W-1:0]        dist_raw_q, dist_raw_d;
  logic [1:0]               dist_id_q, dist_id_d;
  logic                     dist_valid_q, dist_valid_d;
  logic                     dist_timeout_q, dist_timeout_d;
  logic                     busy_q, busy_d;
  logic                     echo_prev_q, echo_prev_d;

  logic [NUM_SENSORS-1:0]   echo_s;
  logic                     echo_sel;
  logic                     rr_found;
  logic [1:0]               rr_pick;
  logic [1:0]               rr_cand;

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_SENSORS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NUM_SENSORS); i++) oh[i] = (idx == 2'(i));
    return oh;
  endfunction

`ifdef PING_SCHED_ECHO_SYNC_EN
  echo_sync #(.WIDTH(NUM_SENSORS)) u_echo_sync (
    .clk (clk),
    .rst (rst),
    .d   (echo),
    .q   (echo_s)
  );
`else
  assign echo_s = echo;
`endif

  assign echo_sel = |(echo_s & onehot(sel_q));

  // Round-robin search starting at the slot after the last one served.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = ptr_q;
    rr_cand  = '0;
    for (int k = 0; k < int'(NUM_SENSORS); k++) begin
      rr_cand = 2'((int'(ptr_q) + k) % int'(NUM_SENSORS));
      if (!rr_found && ((enable_mask & onehot(rr_cand)) != '0)) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = sat_inc(cnt_q);
    sel_d          = sel_q;
    ptr_d          = ptr_q;
    trig_d         = '0;
    dist_raw_d     = dist_raw_q;
    dist_id_d      = dist_id_q;
    dist_valid_d   = 1'b0;
    dist_timeout_d = dist_timeout_q;
    echo_prev_d    = echo_sel;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rr_found) begin
          state_d = ST_TRIG;
          sel_d   = rr_pick;
          ptr_d   = 2'((int'(rr_pick) + 1) % int'(NUM_SENSORS));
          trig_d  = onehot(rr_pick);
        end
      end
      ST_TRIG: begin
        trig_d = onehot(sel_q);
        if (cnt_q >= TRIG_LAST) begin
          state_d = ST_WAIT_ECHO;
          cnt_d   = '0;
          trig_d  = '0;
        end
      end
      ST_WAIT_ECHO: begin
        // The edge sample itself is the first high cycle of the echo.
        if (echo_sel && !echo_prev_q) begin
          state_d = ST_MEASURE;
          cnt_d   = DIST_W'(1);
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d        = ST_GUARD;
          cnt_d          = '0;
          dist_valid_d   = 1'b1;
          dist_timeout_d = 1'b1;
          dist_raw_d     = CNT_TIMEOUT;
          dist_id_d      = sel_q;
        end
      end
      ST_MEASURE: begin
        if (!echo_sel) begin
          state_d        = ST_GUARD;
          cnt_d          = '0;
          dist_valid_d   = 1'b1;
          dist_timeout_d = 1'b0;
          dist_raw_d     = cnt_q;
          dist_id_d      = sel_q;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d        = ST_GUARD;
          cnt_d          = '0;
          dist_valid_d   = 1'b1;
          dist_timeout_d = 1'b1;
          dist_raw_d     = CNT_TIMEOUT;
          dist_id_d      = sel_q;
        end
      end
      ST_GUARD: begin
        if (cnt_q >= GUARD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= '0;
      ptr_q          <= '0;
      trig_q         <= '0;
      dist_raw_q     <= '0;
      dist_id_q      <= '0;
      dist_valid_q   <= 1'b0;
      dist_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
      echo_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      ptr_q          <= ptr_d;
      trig_q         <= trig_d;
      dist_raw_q     <= dist_raw_d;
      dist_id_q      <= dist_id_d;
      dist_valid_q   <= dist_valid_d;
      dist_timeout_q <= dist_timeout_d;
      busy_q         <= busy_d;
      echo_prev_q    <= echo_prev_d;
    end
  end

  assign trig         = trig_q;
  assign dist_raw     = dist_raw_q;
  assign dist_id      = dist_id_q;
  assign dist_valid   = dist_valid_q;
  assign dist_timeout = dist_timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ping_scheduler.sv
// Scoreboard bench for ping_scheduler at CLK_MHZ=1, 3-cycle trigger,
// 1000-cycle timeout, 20-cycle guard, two sensors.
module tb_ping_scheduler;

`ifdef PING_SCHED_ECHO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  enable_mask;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic [20:0] dist_raw;
  logic [1:0]  dist_id;
  logic        dist_valid;
  logic        dist_timeout;
  logic        busy;

  ping_scheduler #(
    .CLK_MHZ          (1),
    .NUM_SENSORS      (2),
    .TRIGGER_PULSE_US (3),
    .TIMEOUT_MS       (1),
    .GUARD_US         (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_mask  (enable_mask),
    .echo         (echo),
    .trig         (trig),
    .dist_raw     (dist_raw),
    .dist_id      (dist_id),
    .dist_valid   (dist_valid),
    .dist_timeout (dist_timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int raw;
    int tout;
  } res_t;

  typedef struct {
    string name;
    int    got;
    int    exp;
  } chk_t;

  res_t exp_q[$];
  chk_t chk_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(input string name, input int got, input int exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  function automatic void expect_result(input int id, input int raw, input int tout);
    res_t r;
    r.id   = id;
    r.raw  = raw;
    r.tout = tout;
    exp_q.push_back(r);
  endfunction

  // Monitor: every comparison is evaluated and counted here.
  initial begin : monitor
    chk_t c;
    res_t e;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_tests++;
        if (c.got != c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d", c.name, c.got, c.exp);
        end
      end
      if (dist_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got id=%0d raw=%0d timeout=%0d, expected no result",
                   dist_id, dist_raw, dist_timeout);
        end else begin
          e = exp_q.pop_front();
          if (int'(dist_id) != e.id || int'(dist_raw) != e.raw || int'(dist_timeout) != e.tout) begin
            n_fail++;
            $display("FAIL result: got id=%0d raw=%0d timeout=%0d, expected id=%0d raw=%0d timeout=%0d",
                     dist_id, dist_raw, dist_timeout, e.id, e.raw, e.tout);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got time %0t, expected completion before limit", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_rise(input int idx, input int limit, output int waited);
    waited = 0;
    while (!trig[idx] && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (!trig[idx]) check($sformatf("trig%0d_rise_bound", idx), 0, 1);
  endtask

  task automatic high_width(input int idx, output int w);
    w = 0;
    while (trig[idx] && w < 50) begin
      w++;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dist_valid && lat < limit);
    if (!dist_valid) check("dist_valid_bound", 0, 1);
  endtask

  // Trigger already high: check width, pulse echo, check result latency.
  task automatic ping_measure(input int idx, input int delay, input int width, input bit noise);
    int w;
    int lat;
    high_width(idx, w);
    check($sformatf("trig%0d_width", idx), w, 3);
    for (int i = 0; i < delay; i++) begin
      if (noise) echo[1-idx] = (i < 4);
      @(negedge clk);
    end
    echo[1-idx] = 1'b0;
    echo[idx] = 1'b1;
    repeat (width) @(negedge clk);
    echo[idx] = 1'b0;
    expect_result(idx, width, 0);
    wait_valid(10, lat);
    check($sformatf("result%0d_latency", idx), lat, 1 + SYNC_LAT);
  endtask

  initial begin : stimulus
    int w;
    int lat;
    int bad;
    rst         = 1'b1;
    enable_mask = 2'b00;
    echo        = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_raw", int'(dist_raw), 0);
    check("rst_id", int'(dist_id), 0);
    enable_mask = 2'b11;
    @(negedge clk);
    check("rst_holds_trig", int'(trig), 0);
    rst = 1'b0;

    // Sensor 0 first, 150-cycle echo, noise on sensor 1.
    wait_rise(0, 5, w);
    check("first_trig_vector", int'(trig), 1);
    ping_measure(0, 10, 150, 1'b1);

    // Guard gap then sensor 1; clearing its enable mid-slot must not abort it.
    wait_rise(1, 40, w);
    check("guard_gap_s1", w, 21);
    enable_mask = 2'b01;
    ping_measure(1, 5, 25, 1'b0);

    // Only sensor 0 enabled; no echo gives a timeout.
    wait_rise(0, 40, w);
    check("guard_gap_s0", w, 21);
    check("trig_vector_s0", int'(trig), 1);
    high_width(0, w);
    check("trig0_width_to", w, 3);
    expect_result(0, 1000, 1);
    wait_valid(1100, lat);
    check("timeout_latency", lat, 1000);

    // Echo activity during guard is ignored; next ping again on sensor 0.
    echo[0] = 1'b1;
    repeat (3) @(negedge clk);
    echo[0] = 1'b0;
    wait_rise(0, 40, w);
    check("guard_gap_after_to", w, 18);
    check("trig_vector_again_s0", int'(trig), 1);

    // Echo already high on WAIT_ECHO entry must be ignored.
    echo[0] = 1'b1;
    high_width(0, w);
    check("trig0_width_prehigh", w, 3);
    repeat (5) @(negedge clk);
    echo[0] = 1'b0;
    repeat (4) @(negedge clk);
    echo[0] = 1'b1;
    repeat (40) @(negedge clk);
    echo[0] = 1'b0;
    expect_result(0, 40, 0);
    wait_valid(10, lat);
    check("prehigh_latency", lat, 1 + SYNC_LAT);

    // No sensors enabled: scheduler stays idle.
    enable_mask = 2'b00;
    repeat (25) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy || trig != 2'b00) bad++;
      @(negedge clk);
    end
    check("idle_activity_cycles", bad, 0);
    check("hold_raw", int'(dist_raw), 40);
    check("hold_id", int'(dist_id), 0);
    check("hold_timeout", int'(dist_timeout), 0);

    enable_mask = 2'b10;
    wait_rise(1, 2, w);
    check("mask_to_trig1_within_2", int'(w >= 1 && w <= 2), 1);

    // Reset during MEASURE of sensor 1.
    high_width(1, w);
    check("trig1_width_rst", w, 3);
    repeat (3) @(negedge clk);
    echo[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_before_rst", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_trig", int'(trig), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(dist_valid), 0);
    echo[1] = 1'b0;
    enable_mask = 2'b11;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (dist_valid) bad++;
    end
    check("valid_during_rst", bad, 0);
    rst = 1'b0;
    w = 0;
    while (trig == 2'b00 && w < 5) begin
      @(negedge clk);
      w++;
    end
    check("post_rst_trig_vector", int'(trig), 1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
